keypad_encoder: RTL and testbench
=================================

KEYPAD_ENCODER -- requirements
Module: keypad_encoder

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, number of consecutive stable samples required to accept a press or release; legal range 1..255.
REQ-002 SHALL have port CLK  input  1  clock; all state changes on rising edge.
REQ-003 SHALL have port RST  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port KEY  input  7  raw asynchronous key lines, active-high; KEY[i] means key code i+1.
REQ-005 SHALL have port CODE  output  3  registered key code for the downstream calculator FSM; 0 means no key.
REQ-006 SHALL have port VALID  output  1  registered one-cycle strobe marking each accepted press.
REQ-007 SHALL have port STATE  output  2  current FSM state, for debug.

Function
REQ-008 SHALL pass KEY through a 2-flop synchronizer; all logic below uses only the synchronized value (SK).
REQ-009 SHALL priority-encode SK to a 3-bit value ENC: highest set index i gives i+1; all zero gives 0.
REQ-010 SHALL implement states IDLE=0, DEBOUNCE=1, PRESSED=2, RELEASE=3, plus an 8-bit stability counter CNT and a 3-bit captured code CAP.
REQ-011 SHALL, in IDLE with ENC!=0, load CAP<=ENC and CNT<=0, and go to DEBOUNCE; with ENC==0, stay in IDLE.
REQ-012 SHALL, in DEBOUNCE with ENC!=CAP (including 0), return to IDLE without asserting VALID or changing CODE.
REQ-013 SHALL, in DEBOUNCE with ENC==CAP, go to PRESSED if CNT==DEBOUNCE_CYCLES-1; otherwise increment CNT.
REQ-014 SHALL, on the DEBOUNCE->PRESSED edge, set VALID=1 for exactly one cycle and CODE<=CAP.
REQ-015 SHALL, in PRESSED, ignore added or changed keys: CAP stays locked until SK is all zero; when SK is all zero, load CNT<=0 and go to RELEASE.
REQ-016 SHALL, in RELEASE with SK all zero, go to IDLE if CNT==DEBOUNCE_CYCLES-1; otherwise increment CNT.
REQ-017 SHALL, in RELEASE with any SK bit set, return to PRESSED with CNT<=0; this SHALL NOT assert VALID.
REQ-018 SHALL hold CODE at CAP through PRESSED and RELEASE, and SHALL clear CODE to 0 on the RELEASE->IDLE edge.
REQ-019 Press latency: if KEY is first sampled high at edge E and held stable, CODE and VALID SHALL update at edge E+DEBOUNCE_CYCLES+2.
REQ-020 Release latency: if KEY is first sampled all-zero at edge R and held, CODE SHALL clear at edge R+DEBOUNCE_CYCLES+2.
REQ-021 A press SHALL produce exactly one VALID per press-release cycle; bounce shorter than DEBOUNCE_CYCLES samples SHALL produce none.

Reset
REQ-022 On RST=1 at a rising edge, the block SHALL set state=IDLE, CNT=0, CAP=0, CODE=0, VALID=0 and both synchronizer flops to 0, regardless of the current state.
REQ-023 After RST deasserts with a key still held, the block SHALL re-debounce per REQ-019 and assert VALID again.

Configuration
REQ-024 SHALL use macro KEYPAD_PULSE_EN.
- Undefined: CODE is held per REQ-018 (level mode).
- Defined: CODE=CAP only in the cycle VALID=1 and 0 at all other times; the FSM is otherwise unchanged.

Verification
REQ-025 RST=1 for 2 cycles, KEY=0 -> CODE=0, VALID=0, STATE=0 throughout.
REQ-026 DEBOUNCE_CYCLES=4, KEY=7'b0000010 held 20 cycles, then 0 -> CODE=2 and a single VALID pulse 6 edges after first sample; CODE=0 6 edges after release sampled.
REQ-027 KEY[2] toggled 1 cycle high / 1 cycle low for 10 cycles, then 0 -> CODE stays 0, VALID never asserted, STATE never reaches 2.
REQ-028 KEY=7'b1000100 pressed together -> CODE=7. In a separate run, KEY=7'b0000100 (CODE=3), then KEY[4] added while held -> CODE stays 3; release all -> CODE=0, one VALID total.
REQ-029 RST pulsed for 1 cycle while in PRESSED with KEY[1] held -> CODE=0 and STATE=0 after that edge; CODE=2 and a second VALID 6 edges later.
REQ-030 With KEYPAD_PULSE_EN defined, the REQ-026 stimulus -> CODE=2 for exactly one cycle, coincident with VALID; 0 otherwise.

Source files
------------

// File: rtl/keypad_encoder.sv
// Debounced 7-key priority encoder. The strobe marks each accepted press.
// Define KEYPAD_PULSE_EN to present CODE only in the VALID cycle. Otherwise CODE holds until release.
module keypad_encoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [6:0] KEY,
    output logic [2:0] CODE,
    output logic       VALID,
    output logic [1:0] STATE
);

    // state    | meaning
    // IDLE     | no key seen, waiting for a nonzero encoded value
    // DEBOUNCE | candidate code captured, counting stable samples
    // PRESSED  | press accepted, code locked until all keys drop
    // RELEASE  | all keys low, counting stable release samples
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [6:0] sync1_q, sync2_q;
    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] cap_q, cap_d;
    logic [2:0] code_q, code_d;
    logic       valid_q, valid_d;
    logic [2:0] enc;
    logic       accept;
    logic       clear;

    always_comb begin
        enc = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (sync2_q[i]) enc = 3'(i + 1);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        accept  = 1'b0;
        clear   = 1'b0;
        case (state_q)
            IDLE: begin
                if (enc != 3'd0) begin
                    cap_d   = enc;
                    cnt_d   = 8'd0;
                    state_d = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (enc != cap_q) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    accept  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            PRESSED: begin
                if (sync2_q == 7'd0) begin
                    cnt_d   = 8'd0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (sync2_q != 7'd0) begin
                    cnt_d   = 8'd0;
                    state_d = PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    clear   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        valid_d = accept;
`ifdef KEYPAD_PULSE_EN
        code_d = accept ? cap_q : 3'd0;
`else
        if (accept)     code_d = cap_q;
        else if (clear) code_d = 3'd0;
        else            code_d = code_q;
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q <= 7'd0;
            sync2_q <= 7'd0;
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            cap_q   <= 3'd0;
            code_q  <= 3'd0;
            valid_q <= 1'b0;
        end else begin
            sync1_q <= KEY;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            code_q  <= code_d;
            valid_q <= valid_d;
        end
    end

    assign CODE  = code_q;
    assign VALID = valid_q;
    assign STATE = state_q;

endmodule

// File: tb/tb_keypad_encoder.sv
// Scoreboard bench for keypad_encoder: a run-length reference model predicts accepted presses and held codes.
module tb_keypad_encoder;

    localparam int D = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [6:0] KEY = 7'd0;
    logic [2:0] CODE;
    logic       VALID;
    logic [1:0] STATE;

    int n_tests = 0;
    int n_fail  = 0;

    keypad_encoder #(.DEBOUNCE_CYCLES(D)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .KEY  (KEY),
        .CODE (CODE),
        .VALID(VALID),
        .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    // Reference model state: a two-sample delay line, plus run lengths of stable codes and of stable releases.
    logic [6:0] m_s1 = 7'd0, m_s2 = 7'd0;
    int         run = 0, zrun = 0;
    logic [2:0] cand = 3'd0, held = 3'd0;
    logic       locked = 1'b0, exp_valid = 1'b0;
    logic [2:0] sb_q[$];

    function automatic logic [2:0] top_code(input logic [6:0] k);
        for (int i = 6; i >= 0; i--) if (k[i]) return 3'(i + 1);
        return 3'd0;
    endfunction

    always @(posedge CLK) begin
        logic [2:0] e;
        exp_valid = 1'b0;
        if (RST) begin
            m_s1 = 7'd0; m_s2 = 7'd0; run = 0; zrun = 0;
            cand = 3'd0; held = 3'd0; locked = 1'b0;
        end else begin
            e = top_code(m_s2);
            if (!locked) begin
                if (run == 0) begin
                    if (e != 3'd0) begin run = 1; cand = e; end
                end else if (e == cand) begin
                    run++;
                    if (run == D + 1) begin
                        locked = 1'b1; run = 0; zrun = 0;
                        held = cand; exp_valid = 1'b1;
                        sb_q.push_back(cand);
                    end
                end else begin
                    run = 0;
                end
            end else begin
                if (m_s2 == 7'd0) begin
                    zrun++;
                    if (zrun == D + 1) begin locked = 1'b0; zrun = 0; held = 3'd0; end
                end else begin
                    zrun = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = KEY;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        logic [2:0] exp_code;
`ifdef KEYPAD_PULSE_EN
        exp_code = exp_valid ? held : 3'd0;
`else
        exp_code = held;
`endif
        check("valid", int'(VALID), int'(exp_valid));
        check("code", int'(CODE), int'(exp_code));
        check("state_locked", int'(STATE[1]), int'(locked));
        if (VALID) begin
            if (sb_q.size() == 0) check("unexpected_valid", 1, 0);
            else check("valid_code", int'(CODE), int'(sb_q.pop_front()));
        end
    end

    task automatic drive(input logic [6:0] k, input int n);
        KEY = k;
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        int waited;
        RST = 1'b1;
        KEY = 7'd0;
        repeat (2) @(negedge CLK);
        check("reset_state", int'(STATE), 0);
        check("reset_code", int'(CODE), 0);
        RST = 1'b0;

        // Single key held, then released.
        drive(7'b0000010, 20);
        drive(7'b0000000, 12);

        // Bounce faster than the debounce window.
        for (int i = 0; i < 5; i++) begin
            drive(7'b0000100, 1);
            drive(7'b0000000, 1);
        end
        drive(7'b0000000, 8);

        // Simultaneous keys: highest wins.
        drive(7'b1000100, 12);
        drive(7'b0000000, 10);

        // A key added while pressed must not change the code.
        drive(7'b0000100, 10);
        drive(7'b0010100, 8);
        drive(7'b0000000, 10);

        // Reset while PRESSED, key still held.
        KEY = 7'b0000010;
        waited = 0;
        while (STATE != 2'd2 && waited < 30) begin
            @(negedge CLK);
            waited++;
        end
        check("reach_pressed", int'(STATE), 2);
        RST = 1'b1;
        @(negedge CLK);
        check("rst_pressed_state", int'(STATE), 0);
        check("rst_pressed_code", int'(CODE), 0);
        RST = 1'b0;
        drive(7'b0000010, 12);
        drive(7'b0000000, 10);

        // Random episodes: clean presses, bounces, changes mid-hold and occasional resets.
        for (int ep = 0; ep < 60; ep++) begin
            logic [6:0] k, k2;
            k  = 7'($urandom_range(1, 127));
            k2 = 7'($urandom_range(0, 127));
            case ($urandom_range(0, 3))
                0: drive(k, $urandom_range(1, 12));
                1: for (int j = 0; j < int'($urandom_range(2, 6)); j++) begin
                       drive(k, $urandom_range(1, D));
                       drive(($urandom_range(0, 1) != 0) ? k2 : 7'd0, $urandom_range(1, 3));
                   end
                2: begin
                       drive(k, $urandom_range(4, 10));
                       drive(k2, $urandom_range(1, 8));
                       drive(7'd0, $urandom_range(1, D + 1));
                       drive(k, $urandom_range(1, 8));
                   end
                default: begin
                       drive(k, $urandom_range(3, 10));
                       if ($urandom_range(0, 3) == 0) begin
                           RST = 1'b1;
                           @(negedge CLK);
                           RST = 1'b0;
                       end
                       drive(k, $urandom_range(1, 10));
                   end
            endcase
            drive(7'd0, $urandom_range(1, 14));
        end

        drive(7'd0, 20);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
